keypad_scan_reader: RTL



---
 rtl/keypad_scan_reader_if.sv | 20 ++
 rtl/keypad_scan_reader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_reader_if.sv
// Keypad scanner signal bundle: matrix rows/columns plus the decoded key-event and BCD entry outputs.
// The scanner takes the master side; the keypad/consumer side takes slave.
interface keypad_scan_reader_if;
    logic [3:0]  io_row;
    logic [3:0]  io_col;
    logic        io_key_valid;
    logic [3:0]  io_key_code;
    logic        io_key_held;
    logic [15:0] io_digits;
    logic [2:0]  io_digit_count;

    modport master (
        input  io_row,
        output io_col, io_key_valid, io_key_code, io_key_held, io_digits, io_digit_count
    );
    modport slave (
        output io_row,
        input  io_col, io_key_valid, io_key_code, io_key_held, io_digits, io_digit_count
    );
endinterface

// File: rtl/keypad_scan_reader.sv
// 4x4 matrix keypad scanner: column rotation, debounced single-key events and 4-digit BCD entry.
// Define KEYPAD_AUTOREPEAT_EN to emit repeated events while a single key stays held.
module keypad_scan_reader #(
    parameter int SCAN_DIV           = 1000,
    parameter int DEBOUNCE_SCANS     = 4,
    parameter int REPEAT_DELAY_SCANS = 64,
    parameter int REPEAT_RATE_SCANS  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    keypad_scan_reader_if.master kp
);
    localparam int            SW        = $clog2(SCAN_DIV);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [3:0]    DEB_N     = 4'(DEBOUNCE_SCANS);

    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 ||
        REPEAT_DELAY_SCANS < 1 || REPEAT_RATE_SCANS < 1) begin : g_param_check
        $error("keypad_scan_reader: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_REL} state_t;

    function automatic logic [3:0] key_map(input logic [3:0] idx);
        case (idx)
            4'd0:    key_map = 4'h1;
            4'd1:    key_map = 4'h2;
            4'd2:    key_map = 4'h3;
            4'd3:    key_map = 4'hA;
            4'd4:    key_map = 4'h4;
            4'd5:    key_map = 4'h5;
            4'd6:    key_map = 4'h6;
            4'd7:    key_map = 4'hB;
            4'd8:    key_map = 4'h7;
            4'd9:    key_map = 4'h8;
            4'd10:   key_map = 4'h9;
            4'd11:   key_map = 4'hC;
            4'd12:   key_map = 4'hE;
            4'd13:   key_map = 4'h0;
            4'd14:   key_map = 4'hF;
            default: key_map = 4'hD;
        endcase
    endfunction

    logic [3:0]    row_s1, row_s2;
    logic [SW-1:0] slot;
    logic [1:0]    col_idx;
    logic [15:0]   snap, snap_full;
    state_t        state, state_nx;
    logic [3:0]    cand, cand_nx, cnt, cnt_nx;
    logic          fire;
    logic          key_valid;
    logic [3:0]    key_code;
    logic [15:0]   digits;
    logic [2:0]    digit_count;
    logic [4:0]    n_keys;
    logic [3:0]    hit_idx, code_now;
    logic          slot_last, scan_end, is_none, is_single;

    assign slot_last = (slot == SLOT_LAST);
    assign scan_end  = slot_last && (col_idx == 2'd3);

    // Current column's sample merged into the snapshot so column 3 is classified on the same edge.
    always_comb begin
        snap_full = snap;
        for (int r = 0; r < 4; r++) snap_full[{2'(r), col_idx}] = ~row_s2[r];
    end

    always_comb begin
        n_keys  = '0;
        hit_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (snap_full[i]) begin
                n_keys  = n_keys + 5'd1;
                hit_idx = 4'(i);
            end
        end
    end

    assign is_none   = (n_keys == 5'd0);
    assign is_single = (n_keys == 5'd1);
    assign code_now  = key_map(hit_idx);

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int            RMAX      = (REPEAT_DELAY_SCANS > REPEAT_RATE_SCANS) ?
                                          REPEAT_DELAY_SCANS : REPEAT_RATE_SCANS;
    localparam int            RW        = $clog2(RMAX + 1);
    localparam logic [RW-1:0] RPT_DELAY = RW'(REPEAT_DELAY_SCANS);
    localparam logic [RW-1:0] RPT_RATE  = RW'(REPEAT_RATE_SCANS);
    logic [RW-1:0] rpt_cnt, rpt_cnt_nx;
    logic          rpt_first, rpt_first_nx;
`endif

    always_comb begin
        state_nx = state;
        cand_nx  = cand;
        cnt_nx   = cnt;
        fire     = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rpt_cnt_nx   = rpt_cnt;
        rpt_first_nx = rpt_first;
`endif
        if (scan_end) begin
            case (state)
                IDLE: if (is_single) begin
                    cand_nx = code_now;
                    cnt_nx  = 4'd1;
                    if (DEB_N == 4'd1) begin
                        fire     = 1'b1;
                        state_nx = PRESSED;
                    end else begin
                        state_nx = DEB_PRESS;
                    end
                end
                DEB_PRESS: if (is_single && code_now == cand) begin
                    cnt_nx = cnt + 4'd1;
                    if (cnt + 4'd1 == DEB_N) begin
                        fire     = 1'b1;
                        state_nx = PRESSED;
                    end
                end else begin
                    state_nx = IDLE;
                end
                PRESSED: begin
                    if (is_none) begin
                        cnt_nx   = 4'd1;
                        state_nx = (DEB_N == 4'd1) ? IDLE : DEB_REL;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    if (is_single && code_now == cand) begin
                        if (rpt_cnt + RW'(1) == (rpt_first ? RPT_DELAY : RPT_RATE)) begin
                            fire         = 1'b1;
                            rpt_cnt_nx   = '0;
                            rpt_first_nx = 1'b0;
                        end else begin
                            rpt_cnt_nx = rpt_cnt + RW'(1);
                        end
                    end else begin
                        rpt_cnt_nx   = '0;
                        rpt_first_nx = 1'b1;
                    end
`endif
                end
                default: if (is_none) begin
                    cnt_nx = cnt + 4'd1;
                    if (cnt + 4'd1 == DEB_N) state_nx = IDLE;
                end else begin
                    state_nx = PRESSED;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            row_s1      <= 4'hF;
            row_s2      <= 4'hF;
            slot        <= '0;
            col_idx     <= '0;
            snap        <= '0;
            state       <= IDLE;
            cand        <= '0;
            cnt         <= '0;
            key_valid   <= 1'b0;
            key_code    <= '0;
            digits      <= '0;
            digit_count <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_cnt     <= '0;
            rpt_first   <= 1'b1;
`endif
        end else begin
            row_s1    <= kp.io_row;
            row_s2    <= row_s1;
            slot      <= slot_last ? '0 : slot + SW'(1);
            state     <= state_nx;
            cand      <= cand_nx;
            cnt       <= cnt_nx;
            key_valid <= fire;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_cnt   <= rpt_cnt_nx;
            rpt_first <= rpt_first_nx;
`endif
            if (slot_last) begin
                col_idx <= col_idx + 2'd1;
                snap    <= scan_end ? '0 : snap_full;
            end
            if (fire) begin
                key_code <= cand_nx;
                if (cand_nx <= 4'd9) begin
                    if (digit_count < 3'd4) begin
                        digits      <= {digits[11:0], cand_nx};
                        digit_count <= digit_count + 3'd1;
                    end
                end else if (cand_nx == 4'hC) begin
                    digits      <= '0;
                    digit_count <= '0;
                end else if (cand_nx == 4'hE && digit_count != 3'd0) begin
                    digits      <= digits >> 4;
                    digit_count <= digit_count - 3'd1;
                end
            end
        end
    end

    assign kp.io_col         = ~(4'b0001 << col_idx);
    assign kp.io_key_valid   = key_valid;
    assign kp.io_key_code    = key_code;
    assign kp.io_key_held    = (state == PRESSED) || (state == DEB_REL);
    assign kp.io_digits      = digits;
    assign kp.io_digit_count = digit_count;
endmodule
